// File: rtl/vote_argmax.sv
// Sequential argmax over per-class vote counts, one class per clock, with a valid/ready result port.
// Optional VOTE_MARGIN_EN adds a runner-up register and the low_conf flag.
module vote_argmax #(
  parameter int bitlength  = 12,
  parameter int output_dim = 10,
  parameter int idx_width  = 4,
  parameter int margin_min = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             vote_finish,
  input  logic [output_dim*bitlength-1:0]  VoteData,
  input  logic                             result_ready,
  output logic                             result_valid,
  output logic [idx_width-1:0]             result_class,
  output logic [bitlength-1:0]             result_count,
  output logic                             no_votes,
  output logic                             busy,
  output logic                             low_conf
);

  if (((2 ** idx_width) < output_dim) || (margin_min < 0)) begin : g_cfg_check
    $error("vote_argmax: idx_width too narrow for output_dim, or negative margin_min");
  end

  typedef enum logic [1:0] {IDLE, SCAN, LATCH, DONE} state_t;

  localparam logic [idx_width-1:0] LAST = idx_width'(output_dim - 1);

  state_t                          state, state_next;
  logic                            finish_q;
  logic                            pending;
  logic [output_dim*bitlength-1:0] snapshot;
  logic [idx_width-1:0]            idx;
  logic [idx_width-1:0]            best_idx;
  logic [bitlength-1:0]            best_cnt;
  logic [bitlength-1:0]            cur;
  logic                            start_evt;
  logic                            capture;

  assign start_evt = vote_finish & ~finish_q;
  assign capture   = (state == IDLE) && (start_evt || pending);
  assign busy      = (state != IDLE);

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < output_dim; i++) begin
      if (idx == idx_width'(i)) cur = snapshot[i*bitlength +: bitlength];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // LATCH spends one cycle moving the final best into the output registers,
  // which yields output_dim+1 edges from start to result_valid.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_evt || pending) state_next = SCAN;
      SCAN:    if (idx == LAST) state_next = LATCH;
      LATCH:   state_next = DONE;
      DONE:    if (result_valid && result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef VOTE_MARGIN_EN
  localparam logic [bitlength-1:0] MARGIN = bitlength'(margin_min);
  logic [bitlength-1:0] second_cnt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finish_q     <= 1'b0;
      pending      <= 1'b0;
      snapshot     <= '0;
      idx          <= '0;
      best_idx     <= '0;
      best_cnt     <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_count <= '0;
      no_votes     <= 1'b0;
`ifdef VOTE_MARGIN_EN
      second_cnt   <= '0;
      low_conf     <= 1'b0;
`endif
    end else begin
      finish_q <= vote_finish;

      // A finish edge while busy is remembered once; repeats collapse into it.
      if (start_evt && (state != IDLE)) pending <= 1'b1;
      else if (capture)                 pending <= 1'b0;

      if (capture) begin
        snapshot <= VoteData;
        idx      <= '0;
        best_idx <= '0;
        best_cnt <= '0;
`ifdef VOTE_MARGIN_EN
        second_cnt <= '0;
`endif
      end

      if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (cur > best_cnt) begin
          best_cnt <= cur;
          best_idx <= idx;
`ifdef VOTE_MARGIN_EN
          second_cnt <= best_cnt;
`endif
        end
`ifdef VOTE_MARGIN_EN
        else if (cur > second_cnt) begin
          second_cnt <= cur;
        end
`endif
      end

      if (state == LATCH) begin
        result_valid <= 1'b1;
        result_class <= best_idx;
        result_count <= best_cnt;
        no_votes     <= (best_cnt == '0);
`ifdef VOTE_MARGIN_EN
        low_conf     <= ((best_cnt - second_cnt) < MARGIN);
`endif
      end

      if ((state == DONE) && result_valid && result_ready) result_valid <= 1'b0;
    end
  end

`ifndef VOTE_MARGIN_EN
  assign low_conf = 1'b0;
`endif

endmodule

// File: tb/tb_vote_argmax.sv
// Directed bench for vote_argmax: vector table plus handshake, re-trigger and reset sequences.
module tb_vote_argmax;
  localparam int BL = 12;
  localparam int OD = 10;
  localparam int IW = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              vote_finish;
  logic [OD*BL-1:0]  VoteData;
  logic              result_ready;
  logic              result_valid;
  logic [IW-1:0]     result_class;
  logic [BL-1:0]     result_count;
  logic              no_votes;
  logic              busy;
  logic              low_conf;

  int checks   = 0;
  int failures = 0;

  vote_argmax #(.bitlength(BL), .output_dim(OD), .idx_width(IW), .margin_min(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .vote_finish  (vote_finish),
    .VoteData     (VoteData),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_count (result_count),
    .no_votes     (no_votes),
    .busy         (busy),
    .low_conf     (low_conf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OD*BL-1:0] votes;
    int               cls;
    int               cnt;
    int               nov;
    int               low;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [OD*BL-1:0] pk(input int v[OD]);
    logic [OD*BL-1:0] r;
    r = '0;
    for (int i = 0; i < OD; i++) r[i*BL +: BL] = BL'(v[i]);
    return r;
  endfunction

  function automatic int exp_low(input int low);
`ifdef VOTE_MARGIN_EN
    return low;
`else
    return (low != 0) ? 0 : 0;
`endif
  endfunction

  // Raise finish, then count edges after the sampling edge until result_valid (bounded).
  task automatic start_and_wait(output int lat, output bit ok);
    @(negedge clock);
    vote_finish = 1'b1;
    @(posedge clock);
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      lat++;
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  t[OD];
    int  lat;
    bit  ok;
    int  unstable;
    int  spurious;

    reset        = 1'b0;
    vote_finish  = 1'b0;
    VoteData     = '0;
    result_ready = 1'b1;

    t = '{3,0,7,1,0,0,9,2,0,4};          vecs[0] = '{pk(t), 6, 9, 0, 1};
    t = '{0,5,5,0,0,0,0,0,0,0};          vecs[1] = '{pk(t), 1, 5, 0, 1};
    t = '{0,0,0,0,0,0,0,0,0,0};          vecs[2] = '{pk(t), 0, 0, 1, 1};
    t = '{1,1,1,1,1,1,1,1,1,4095};       vecs[3] = '{pk(t), 9, 4095, 0, 0};
    t = '{7,7,7,7,7,7,7,7,7,7};          vecs[4] = '{pk(t), 0, 7, 0, 1};
    t = '{0,0,0,0,0,0,0,0,0,1};          vecs[5] = '{pk(t), 9, 1, 0, 1};
    t = '{0,0,12,0,0,0,0,9,0,0};         vecs[6] = '{pk(t), 2, 12, 0, 1};
    t = '{0,0,20,0,0,0,0,9,0,0};         vecs[7] = '{pk(t), 2, 20, 0, 0};

    repeat (2) @(negedge clock);
    chk("reset_valid", int'(result_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_class", int'(result_class), 0);
    chk("reset_count", int'(result_count), 0);
    chk("reset_novotes", int'(no_votes), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int k = 0; k < 8; k++) begin
      VoteData = vecs[k].votes;
      start_and_wait(lat, ok);
      chk($sformatf("v%0d_latency", k), ok ? lat : -1, 11);
      chk($sformatf("v%0d_class", k), int'(result_class), vecs[k].cls);
      chk($sformatf("v%0d_count", k), int'(result_count), vecs[k].cnt);
      chk($sformatf("v%0d_novotes", k), int'(no_votes), vecs[k].nov);
      chk($sformatf("v%0d_lowconf", k), int'(low_conf), exp_low(vecs[k].low));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_valid_drop", k), int'(result_valid), 0);
      @(negedge clock);
      vote_finish = 1'b0;
      @(negedge clock);
      chk($sformatf("v%0d_idle", k), int'(busy), 0);
    end

    // Backpressure: result must hold while ready is low and inputs change.
    result_ready = 1'b0;
    VoteData = vecs[0].votes;
    start_and_wait(lat, ok);
    chk("hold_latency", ok ? lat : -1, 11);
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      VoteData = {$urandom, $urandom, $urandom, $urandom};
      if (!result_valid || result_class != 4'd6 || result_count != 12'd9 || !busy) unstable++;
    end
    chk("hold_stable_cycles", unstable, 0);
    result_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("hold_valid_drop", int'(result_valid), 0);
    chk("hold_idle", int'(busy), 0);
    chk("hold_class_kept", int'(result_class), 6);
    @(negedge clock);
    vote_finish = 1'b0;
    @(negedge clock);

    // Re-trigger during SCAN: first result from the original capture, then a second scan.
    VoteData = vecs[0].votes;
    @(negedge clock);
    vote_finish = 1'b1;
    @(posedge clock);
    #1;
    VoteData = vecs[1].votes;
    @(negedge clock);
    vote_finish = 1'b0;
    @(negedge clock);
    vote_finish = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("retrig_first_seen", int'(ok), 1);
    chk("retrig_first_class", int'(result_class), 6);
    chk("retrig_first_count", int'(result_count), 9);
    @(posedge clock);
    #1;
    chk("retrig_first_drop", int'(result_valid), 0);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("retrig_second_seen", int'(ok), 1);
    chk("retrig_second_class", int'(result_class), 1);
    chk("retrig_second_count", int'(result_count), 5);
    @(negedge clock);
    vote_finish = 1'b0;
    repeat (2) @(negedge clock);

    // Reset on scan cycle 4 clears everything at once; nothing follows until a new finish edge.
    VoteData = vecs[3].votes;
    @(negedge clock);
    vote_finish = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    chk("midscan_busy_before", int'(busy), 1);
    reset = 1'b0;
    vote_finish = 1'b0;
    #1;
    chk("midscan_rst_busy", int'(busy), 0);
    chk("midscan_rst_valid", int'(result_valid), 0);
    chk("midscan_rst_class", int'(result_class), 0);
    chk("midscan_rst_count", int'(result_count), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    spurious = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (result_valid || busy) spurious++;
    end
    chk("after_reset_quiet", spurious, 0);
    start_and_wait(lat, ok);
    chk("after_reset_latency", ok ? lat : -1, 11);
    chk("after_reset_class", int'(result_class), 9);
    chk("after_reset_count", int'(result_count), 4095);
    @(negedge clock);
    vote_finish = 1'b0;
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
